// File: rtl/regfile_wb.sv
// Y86 write-back stage: serialises retiring E/M results onto the single
// register-file write port, tracks halt, bad destinations and retire count.
module regfile_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int REGNUM = 8,
    parameter int NOREG  = 'h0F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_dstE,
    input  logic [DATA_W-1:0] in_valE,
    input  logic [ADDR_W-1:0] in_dstM,
    input  logic [DATA_W-1:0] in_valM,
    input  logic              in_halt,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              halted,
    output logic              bad_dst,
    output logic [31:0]       retired
);

    localparam logic [ADDR_W-1:0] NO = ADDR_W'(NOREG);
    localparam logic [ADDR_W-1:0] RN = ADDR_W'(REGNUM);

    typedef enum logic [1:0] {IDLE, WR_E, WR_M, HALTED} state_t;

    state_t            state_q, state_d;
    logic              m_pend;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;

    logic              accept;
    logic              e_bad, m_bad;
    logic [ADDR_W-1:0] e_id, m_id;
    logic              has_e, has_m;

    always_comb begin
        e_bad = (in_dstE != NO) && (in_dstE >= RN);
        m_bad = (in_dstM != NO) && (in_dstM >= RN);
        e_id  = e_bad ? NO : in_dstE;
        m_id  = m_bad ? NO : in_dstM;
        has_m = (m_id != NO);
        // popl %esp: both target the same register, the memory value wins
        has_e = (e_id != NO) && (e_id != m_id);
    end

    assign in_ready = (state_q == IDLE)
                    | ((state_q == WR_E) & ~m_pend)
                    | (state_q == WR_M);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HALTED: state_d = HALTED;
            default: begin
                if (accept) begin
                    if (in_halt)    state_d = HALTED;
                    else if (has_e) state_d = WR_E;
                    else if (has_m) state_d = WR_M;
                    else            state_d = IDLE;
                end else if (state_q == WR_E && m_pend) begin
                    state_d = WR_M;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            m_pend    <= 1'b0;
            pend_addr <= NO;
            pend_data <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= NO;
            wr_data   <= '0;
            halted    <= 1'b0;
            bad_dst   <= 1'b0;
            retired   <= '0;
        end else begin
            state_q <= state_d;
            wr_en   <= 1'b0;
            if (accept) begin
                m_pend <= 1'b0;
                if (in_halt) begin
                    halted <= 1'b1;
                end else begin
                    retired <= retired + 32'd1;
                    if (e_bad || m_bad) bad_dst <= 1'b1;
                    if (has_e) begin
                        wr_en     <= 1'b1;
                        wr_addr   <= e_id;
                        wr_data   <= in_valE;
                        m_pend    <= has_m;
                        pend_addr <= m_id;
                        pend_data <= in_valM;
                    end else if (has_m) begin
                        wr_en   <= 1'b1;
                        wr_addr <= m_id;
                        wr_data <= in_valM;
                    end
                end
            end else if (m_pend) begin
                wr_en   <= 1'b1;
                wr_addr <= pend_addr;
                wr_data <= pend_data;
                m_pend  <= 1'b0;
            end
        end
    end

endmodule
